// File: rtl/cci_mpf_shim_vtp_svc_client.sv
// VTP service client: fully-associative L1 translation cache with one outstanding service lookup.
// Defining CCI_MPF_VTP_CLIENT_STATS_EN adds saturating hit/miss counters (stat_hits, stat_misses).
`timescale 1ns/1ps
module cci_mpf_shim_vtp_svc_client #(
    parameter int unsigned N_ENTRIES         = 8,
    parameter int unsigned VA_PAGE_BITS      = 36,
    parameter int unsigned PA_PAGE_BITS      = 28,
    parameter int unsigned BIG_PAGE_IDX_BITS = 9
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_en,
    input  logic [VA_PAGE_BITS-1:0] req_va,
    output logic                    req_rdy,
    output logic                    rsp_valid,
    output logic [PA_PAGE_BITS-1:0] rsp_pa,
    output logic                    rsp_is_big_page,
    output logic                    svc_lookup_en,
    output logic [VA_PAGE_BITS-1:0] svc_lookup_va,
    input  logic                    svc_lookup_rdy,
    input  logic                    svc_rsp_valid,
    input  logic [PA_PAGE_BITS-1:0] svc_rsp_pa,
    input  logic                    svc_rsp_is_big_page,
    input  logic                    inval_en
`ifdef CCI_MPF_VTP_CLIENT_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses
`endif
);
    localparam int unsigned PTR_W = $clog2(N_ENTRIES);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t                  state, state_next;
    logic [VA_PAGE_BITS-1:0] va_q;
    logic [N_ENTRIES-1:0]    valid;
    logic [N_ENTRIES-1:0]    tag_big;
    logic [VA_PAGE_BITS-1:0] tag_va [N_ENTRIES];
    logic [PA_PAGE_BITS-1:0] tag_pa [N_ENTRIES];
    logic [PTR_W-1:0]        ptr;

    logic [N_ENTRIES-1:0]    match;
    logic [PA_PAGE_BITS-1:0] hit_pa;
    logic                    hit_big;
    logic                    hit_c;

    logic                    va_load, fill;
    logic                    req_rdy_d, rsp_valid_d, rsp_big_d, lookup_en_d;
    logic [PA_PAGE_BITS-1:0] rsp_pa_d;

    // 2MB pages carry the VA's low page-index bits into the PA.
    function automatic logic [PA_PAGE_BITS-1:0] merge_pa(
        input logic [PA_PAGE_BITS-1:0]      pa,
        input logic                         big,
        input logic [BIG_PAGE_IDX_BITS-1:0] va_lo
    );
        merge_pa = pa;
        if (big) merge_pa[BIG_PAGE_IDX_BITS-1:0] = va_lo;
    endfunction

    // Tag compare on the registered VA; at most one entry is expected to match.
    always_comb begin
        match   = '0;
        hit_pa  = '0;
        hit_big = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid[i] && (tag_big[i]
                    ? (tag_va[i][VA_PAGE_BITS-1:BIG_PAGE_IDX_BITS] == va_q[VA_PAGE_BITS-1:BIG_PAGE_IDX_BITS])
                    : (tag_va[i] == va_q))) begin
                match[i] = 1'b1;
                hit_pa   = hit_pa | tag_pa[i];
                hit_big  = hit_big | tag_big[i];
            end
        end
        hit_c = (|match) && !inval_en;
    end

    always_comb begin
        state_next  = state;
        va_load     = 1'b0;
        fill        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_pa_d    = rsp_pa;
        rsp_big_d   = rsp_is_big_page;
        unique case (state)
            S_IDLE: begin
                if (req_en && req_rdy) begin
                    va_load    = 1'b1;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_pa_d    = merge_pa(hit_pa, hit_big, va_q[BIG_PAGE_IDX_BITS-1:0]);
                    rsp_big_d   = hit_big;
                    state_next  = S_IDLE;
                end else begin
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (svc_lookup_en && svc_lookup_rdy) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (svc_rsp_valid) begin
                    fill        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_pa_d    = merge_pa(svc_rsp_pa, svc_rsp_is_big_page, va_q[BIG_PAGE_IDX_BITS-1:0]);
                    rsp_big_d   = svc_rsp_is_big_page;
                    state_next  = S_RESPOND;
                end
            end
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        req_rdy_d   = (state_next == S_IDLE);
        lookup_en_d = (state_next == S_ISSUE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            va_q            <= '0;
            req_rdy         <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_pa          <= '0;
            rsp_is_big_page <= 1'b0;
            svc_lookup_en   <= 1'b0;
            valid           <= '0;
            ptr             <= '0;
        end else begin
            state           <= state_next;
            req_rdy         <= req_rdy_d;
            rsp_valid       <= rsp_valid_d;
            rsp_pa          <= rsp_pa_d;
            rsp_is_big_page <= rsp_big_d;
            svc_lookup_en   <= lookup_en_d;
            if (va_load) va_q <= req_va;
            // Invalidate clears old entries; a same-cycle fill still lands valid.
            if (inval_en) begin
                valid <= '0;
                ptr   <= '0;
            end
            if (fill) begin
                valid[ptr] <= 1'b1;
                if (!inval_en) ptr <= ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_va[ptr]  <= va_q;
            tag_pa[ptr]  <= svc_rsp_pa;
            tag_big[ptr] <= svc_rsp_is_big_page;
        end
    end

    assign svc_lookup_va = va_q;

`ifdef CCI_MPF_VTP_CLIENT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (state == S_LOOKUP && hit_c && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
            if (fill && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

    a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
        (state == S_LOOKUP) |-> $onehot0(match));
    a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!reset_n)
        svc_rsp_valid |-> (state == S_WAIT));

endmodule

// File: tb/tb_cci_mpf_shim_vtp_svc_client.sv
// Bench for cci_mpf_shim_vtp_svc_client: directed cases plus random requests against a cache model.
`timescale 1ns/1ps
module tb_cci_mpf_shim_vtp_svc_client;
    localparam int unsigned N   = 8;
    localparam int unsigned VAW = 36;
    localparam int unsigned PAW = 28;
    localparam int unsigned BB  = 9;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           req_en;
    logic [VAW-1:0] req_va;
    logic           req_rdy;
    logic           rsp_valid;
    logic [PAW-1:0] rsp_pa;
    logic           rsp_is_big_page;
    logic           svc_lookup_en;
    logic [VAW-1:0] svc_lookup_va;
    logic           svc_lookup_rdy;
    logic           svc_rsp_valid;
    logic [PAW-1:0] svc_rsp_pa;
    logic           svc_rsp_is_big_page;
    logic           inval_en;
`ifdef CCI_MPF_VTP_CLIENT_STATS_EN
    logic [31:0]    stat_hits, stat_misses;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Reference cache: list of (va, pa, big, valid) with a round-robin victim index.
    logic [63:0] m_va    [N];
    logic [63:0] m_pa    [N];
    logic        m_big   [N];
    logic        m_valid [N];
    int          m_ptr;

    cci_mpf_shim_vtp_svc_client #(
        .N_ENTRIES(N), .VA_PAGE_BITS(VAW), .PA_PAGE_BITS(PAW), .BIG_PAGE_IDX_BITS(BB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_en(req_en), .req_va(req_va), .req_rdy(req_rdy),
        .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_is_big_page(rsp_is_big_page),
        .svc_lookup_en(svc_lookup_en), .svc_lookup_va(svc_lookup_va), .svc_lookup_rdy(svc_lookup_rdy),
        .svc_rsp_valid(svc_rsp_valid), .svc_rsp_pa(svc_rsp_pa), .svc_rsp_is_big_page(svc_rsp_is_big_page),
        .inval_en(inval_en)
`ifdef CCI_MPF_VTP_CLIENT_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_inval();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic void mdl_fill(input logic [63:0] va, input logic [63:0] pa, input logic big);
        m_va[m_ptr]    = va;
        m_pa[m_ptr]    = pa;
        m_big[m_ptr]   = big;
        m_valid[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % N;
    endfunction

    function automatic logic [63:0] big_merge(input logic [63:0] pa, input logic [63:0] va);
        return (pa / 64'd512) * 64'd512 + (va % 64'd512);
    endfunction

    function automatic void mdl_find(input logic [63:0] va, output logic hit,
                                     output logic [63:0] pa, output logic big);
        hit = 1'b0; pa = 64'd0; big = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && (m_big[i] ? (va / 64'd512 == m_va[i] / 64'd512) : (va == m_va[i]))) begin
                hit = 1'b1;
                big = m_big[i];
                pa  = m_big[i] ? big_merge(m_pa[i], va) : m_pa[i];
            end
        end
    endfunction

    // Service page table: VAs with bit 20 set live in 2MB pages.
    function automatic void page_table(input logic [63:0] va, output logic [63:0] pa, output logic big);
        big = ((va / 64'h100000) % 64'd2) == 64'd1;
        if (big) pa = (((va / 64'd512) * 64'd13 + 64'd5) * 64'd512) % 64'h10000000;
        else     pa = (va * 64'd7 + 64'd3) % 64'h10000000;
    endfunction

    task automatic inval_pulse();
        @(negedge clk); inval_en = 1'b1;
        @(negedge clk); inval_en = 1'b0;
        mdl_inval();
    endtask

    // One translation request with the bench acting as the VTP service.
    task automatic do_req(input string tag, input logic [63:0] va, input logic [63:0] spa,
                          input logic sbig, input int delay, input int bp, input bit inv_wait);
        logic        ehit, ebig;
        logic [63:0] epa;
        int          t, cnt, inv_stage, n_xfer, n_en, rsp_t;
        bit          done;
        mdl_find(va, ehit, epa, ebig);
        if (!ehit) begin
            if (inv_wait) mdl_inval();
            mdl_fill(va, spa, sbig);
            epa = sbig ? big_merge(spa, va) : spa;
            ebig = sbig;
            exp_misses++;
        end else begin
            exp_hits++;
        end

        t = 0;
        while (req_rdy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        check({tag, "_rdy_idle"}, 64'(req_rdy), 64'd1);
        req_en = 1'b1;
        req_va = VAW'(va);
        @(negedge clk);
        req_en = 1'b0;

        cnt = 0; inv_stage = 0; n_xfer = 0; n_en = 0; rsp_t = 0; done = 1'b0;
        for (t = 1; t < 200; t++) begin
            inval_en = 1'b0;
            if (inv_stage == 1) begin inval_en = 1'b1; inv_stage = 2; end
            svc_rsp_valid  = 1'b0;
            svc_lookup_rdy = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    svc_rsp_valid = 1'b1;
                    svc_rsp_pa = PAW'(spa);
                    svc_rsp_is_big_page = sbig;
                    rsp_t = t;
                end
            end
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
            check({tag, "_rdy_busy"}, 64'(req_rdy), 64'd0);
            if (svc_lookup_en === 1'b1) begin
                n_en++;
                check({tag, "_lk_va"}, 64'(svc_lookup_va), va);
                if (n_en > bp) begin
                    svc_lookup_rdy = 1'b1;
                    n_xfer++;
                    cnt = delay;
                    if (inv_wait) inv_stage = 1;
                end
            end
            @(negedge clk);
        end
        svc_rsp_valid = 1'b0; svc_lookup_rdy = 1'b0; inval_en = 1'b0;

        check({tag, "_done"}, 64'(done), 64'd1);
        if (done) begin
            check({tag, "_lat"}, 64'(t), ehit ? 64'd2 : 64'(rsp_t + 1));
            check({tag, "_pa"}, 64'(rsp_pa), epa);
            check({tag, "_big"}, 64'(rsp_is_big_page), 64'(ebig));
            check({tag, "_xfers"}, 64'(n_xfer), ehit ? 64'd0 : 64'd1);
            check({tag, "_en_cycles"}, 64'(n_en), ehit ? 64'd0 : 64'(bp + 1));
            check({tag, "_rdy_rsp"}, 64'(req_rdy), 64'(ehit));
        end
    endtask

    initial begin
        reset_n = 1'b0; req_en = 1'b0; req_va = '0; svc_lookup_rdy = 1'b0;
        svc_rsp_valid = 1'b0; svc_rsp_pa = '0; svc_rsp_is_big_page = 1'b0; inval_en = 1'b0;
        mdl_inval();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("rst_rdy", 64'(req_rdy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_lk_en", 64'(svc_lookup_en), 64'd0);
        check("rst_rsp_pa", 64'(rsp_pa), 64'd0);
        check("rst_lk_va", 64'(svc_lookup_va), 64'd0);
        @(negedge clk);
        check("rst_rdy_after", 64'(req_rdy), 64'd1);

        do_req("cold", 64'h000012345, 64'h0ABCD, 1'b0, 5, 0, 1'b0);
        do_req("warm", 64'h000012345, 64'h0, 1'b0, 1, 0, 1'b0);
        do_req("big_miss", 64'h000040000, 64'h0200000, 1'b1, 3, 0, 1'b0);
        do_req("big_hit", 64'h0000401F3, 64'h0, 1'b0, 1, 0, 1'b0);
        do_req("bp", 64'h000077000, 64'h0000777, 1'b0, 2, 10, 1'b0);

        inval_pulse();
        do_req("inv_miss", 64'h000012345, 64'h0ABCD, 1'b0, 2, 0, 1'b0);

        inval_pulse();
        for (int i = 0; i < 9; i++)
            do_req("wrap_fill", 64'h1000 + 64'(i), 64'h500 + 64'(i), 1'b0, 1 + (i % 3), 0, 1'b0);
        do_req("wrap_first", 64'h1000, 64'h500, 1'b0, 2, 0, 1'b0);
        do_req("wrap_ninth", 64'h1008, 64'h0, 1'b0, 1, 0, 1'b0);

        do_req("inv_wait", 64'h2222, 64'h3333, 1'b0, 4, 1, 1'b1);
        do_req("inv_wait_hit", 64'h2222, 64'h0, 1'b0, 1, 0, 1'b0);
        do_req("inv_wait_gone", 64'h1008, 64'h508, 1'b0, 2, 0, 1'b0);

        inval_pulse();
        for (int i = 0; i < 150; i++) begin
            logic [63:0] va, pa;
            logic        big;
            int          d, b;
            bit          iw;
            if ($urandom_range(0, 1) == 0)
                va = 64'h100 + 64'($urandom_range(0, 11));
            else
                va = 64'h100000 + 64'($urandom_range(0, 2)) * 64'd512 + 64'($urandom_range(0, 511));
            page_table(va, pa, big);
            d  = int'($urandom_range(1, 6));
            b  = int'($urandom_range(0, 3));
            iw = (d >= 2) && ($urandom_range(0, 14) == 0);
            do_req("rand", va, pa, big, d, b, iw);
            if ($urandom_range(0, 9) == 0) inval_pulse();
        end

`ifdef CCI_MPF_VTP_CLIENT_STATS_EN
        check("stat_hits", 64'(stat_hits), 64'(exp_hits));
        check("stat_misses", 64'(stat_misses), 64'(exp_misses));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
